// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage divide port bundle.
//   master : pipeline side (drives request, receives stall/results)
//   slave  : divider side
//   E_div_valid/E_div_signed/E_div_cancel/E_div_srca/E_div_srcb : request
//   E_div_stall/E_div_ready/E_div_lo/E_div_hi                    : response
interface div_unit_if #(
   parameter int DATA_W = 32
);
   logic              E_div_valid;
   logic              E_div_signed;
   logic              E_div_cancel;
   logic [DATA_W-1:0] E_div_srca;
   logic [DATA_W-1:0] E_div_srcb;
   logic              E_div_stall;
   logic              E_div_ready;
   logic [DATA_W-1:0] E_div_lo;
   logic [DATA_W-1:0] E_div_hi;

   modport master (
      output E_div_valid, E_div_signed, E_div_cancel, E_div_srca, E_div_srcb,
      input  E_div_stall, E_div_ready, E_div_lo, E_div_hi
   );

   modport slave (
      input  E_div_valid, E_div_signed, E_div_cancel, E_div_srca, E_div_srcb,
      output E_div_stall, E_div_ready, E_div_lo, E_div_hi
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for the execute stage.
// One quotient bit per cycle; stalls the pipeline while working and presents
// quotient (lo) / remainder (hi) for one cycle in DONE.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   div    : div_unit_if.slave (request, stall, ready, lo/hi results)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a DIV/DIVU in E; stall follows E_div_valid
// BUSY  | shifting/subtracting, one quotient bit per cycle
// DONE  | lo/hi valid, ready=1 for one cycle, then back to IDLE
module div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input logic       clk,
   input logic       resetn,
   div_unit_if.slave div
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dvd_q, dvd_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [DATA_W-1:0] srca_q, srca_d;
   logic              qsign_q, qsign_d;
   logic              rsign_q, rsign_d;
   logic              dz_q, dz_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] hi_q, hi_d;

   logic              a_neg, b_neg;
   logic [DATA_W-1:0] a_abs, b_abs;
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W:0]   diff;
   logic              ge;
   logic [DATA_W-1:0] rem_nx, quo_nx;
   logic [DATA_W-1:0] q_fix, r_fix;

   assign a_neg = div.E_div_signed & div.E_div_srca[DATA_W-1];
   assign b_neg = div.E_div_signed & div.E_div_srcb[DATA_W-1];
   assign a_abs = a_neg ? (~div.E_div_srca + 1'b1) : div.E_div_srca;
   assign b_abs = b_neg ? (~div.E_div_srcb + 1'b1) : div.E_div_srcb;

   // Shifted partial remainder can reach 2*divisor-1, so the compare and
   // subtract carry one extra bit; diff's MSB is the borrow.
   assign rem_sh = {rem_q, dvd_q[DATA_W-1]};
   assign diff   = rem_sh - {1'b0, dvs_q};
   assign ge     = ~diff[DATA_W];
   assign rem_nx = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
   assign quo_nx = {quo_q[DATA_W-2:0], ge};

   // Sign fix-up uses the final step's values directly so lo/hi load on DONE entry.
   assign q_fix = qsign_q ? (~quo_nx + 1'b1) : quo_nx;
   assign r_fix = rsign_q ? (~rem_nx + 1'b1) : rem_nx;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      srca_d  = srca_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      dz_d    = dz_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      case (state_q)
         S_IDLE: begin
            if (div.E_div_valid && !div.E_div_cancel) begin
               state_d = S_BUSY;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = '0;
               dvd_d   = a_abs;
               dvs_d   = b_abs;
               srca_d  = div.E_div_srca;
               qsign_d = a_neg ^ b_neg;
               rsign_d = a_neg;
               dz_d    = (div.E_div_srcb == '0);
            end
         end
         S_BUSY: begin
            if (div.E_div_cancel) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
                  lo_d    = dz_q ? '1     : q_fix;
                  hi_d    = dz_q ? srca_q : r_fix;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         srca_q  <= '0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         dz_q    <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         srca_q  <= srca_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         dz_q    <= dz_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
      end
   end

   // Combinational so the pipeline freezes in the same cycle the divide reaches E.
   assign div.E_div_stall = ~div.E_div_cancel &
                            (((state_q == S_IDLE) & div.E_div_valid) | (state_q == S_BUSY));
   assign div.E_div_ready = (state_q == S_DONE);
   assign div.E_div_lo    = lo_q;
   assign div.E_div_hi    = hi_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
   } exp_t;

   logic clk;
   logic resetn;
   int   tests;
   int   fails;
   exp_t sb[$];

   div_unit_if #(.DATA_W(32)) dif ();

   div_unit #(.DATA_W(32), .CNT_W(5)) dut (
      .clk    (clk),
      .resetn (resetn),
      .div    (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called 1ns after a rising edge with the block in IDLE. Drives the
   // request, follows it to DONE and returns 1ns after the edge that ends DONE.
   task automatic run_div(input string name, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi);
      int   cyc;
      int   nst;
      exp_t e;
      dif.E_div_valid  = 1'b1;
      dif.E_div_signed = sgn;
      dif.E_div_srca   = a;
      dif.E_div_srcb   = b;
      dif.E_div_cancel = 1'b0;
      sb.push_back({elo, ehi});
      #1;
      chk({name, "_stall_t0"}, 32'(dif.E_div_stall), 32'd1);
      cyc = 0;
      nst = 0;
      while (dif.E_div_ready !== 1'b1 && cyc < 40) begin
         if (dif.E_div_stall === 1'b1) nst++;
         @(posedge clk);
         #2;
         cyc++;
      end
      chk({name, "_latency"}, 32'(cyc), 32'd33);
      chk({name, "_stall_cycles"}, 32'(nst), 32'd33);
      chk({name, "_done_stall"}, 32'(dif.E_div_stall), 32'd0);
      e = sb.pop_front();
      chk({name, "_lo"}, dif.E_div_lo, e.lo);
      chk({name, "_hi"}, dif.E_div_hi, e.hi);
      @(posedge clk);
      #1;
      chk({name, "_ready_pulse"}, 32'(dif.E_div_ready), 32'd0);
   endtask

   initial begin
      bit rdy_seen;
      tests = 0;
      fails = 0;
      resetn           = 1'b0;
      dif.E_div_valid  = 1'b0;
      dif.E_div_signed = 1'b0;
      dif.E_div_cancel = 1'b0;
      dif.E_div_srca   = '0;
      dif.E_div_srcb   = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", 32'(dif.E_div_stall), 32'd0);
      chk("rst_ready", 32'(dif.E_div_ready), 32'd0);
      chk("rst_lo", dif.E_div_lo, 32'd0);
      chk("rst_hi", dif.E_div_hi, 32'd0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Basic unsigned, then drop valid at T34: a restart in DONE would show as stall.
      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      dif.E_div_valid = 1'b0;
      #1;
      chk("no_restart1_stall", 32'(dif.E_div_stall), 32'd0);
      @(posedge clk);
      #1;

      // Signed cases, overflow, divide by zero and wide divisor, back to back.
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
      run_div("divu_wide", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE);

      // Explicit consecutive pair; second stall must rise at T34.
      run_div("b2b_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      run_div("b2b_50_6", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2);
      dif.E_div_valid = 1'b0;
      #1;
      chk("no_restart2_stall", 32'(dif.E_div_stall), 32'd0);
      @(posedge clk);
      #1;

      // Cancel at T10 of a 100/7.
      rdy_seen = 1'b0;
      dif.E_div_valid  = 1'b1;
      dif.E_div_signed = 1'b0;
      dif.E_div_srca   = 32'd100;
      dif.E_div_srcb   = 32'd7;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (dif.E_div_ready === 1'b1) rdy_seen = 1'b1;
      end
      dif.E_div_cancel = 1'b1;
      #1;
      chk("cancel_stall_tk", 32'(dif.E_div_stall), 32'd0);
      @(posedge clk);
      #1;
      dif.E_div_cancel = 1'b0;
      dif.E_div_valid  = 1'b0;
      #1;
      if (dif.E_div_ready === 1'b1) rdy_seen = 1'b1;
      chk("cancel_idle_stall", 32'(dif.E_div_stall), 32'd0);
      chk("cancel_no_ready", 32'(rdy_seen), 32'd0);
      chk("cancel_lo_hold", dif.E_div_lo, 32'd8);
      chk("cancel_hi_hold", dif.E_div_hi, 32'd2);
      @(posedge clk);
      #1;
      run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
      dif.E_div_valid = 1'b0;
      @(posedge clk);
      #1;

      // Reset at T15; the pipeline's own reset also clears the E-stage valid.
      dif.E_div_valid = 1'b1;
      dif.E_div_srca  = 32'd100;
      dif.E_div_srcb  = 32'd7;
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      resetn          = 1'b0;
      dif.E_div_valid = 1'b0;
      #1;
      chk("mid_rst_stall", 32'(dif.E_div_stall), 32'd0);
      chk("mid_rst_ready", 32'(dif.E_div_ready), 32'd0);
      chk("mid_rst_lo", dif.E_div_lo, 32'd0);
      chk("mid_rst_hi", dif.E_div_hi, 32'd0);
      @(posedge clk);
      #1;
      resetn   = 1'b1;
      rdy_seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (dif.E_div_ready === 1'b1 || dif.E_div_stall === 1'b1) rdy_seen = 1'b1;
      end
      chk("post_rst_quiet", 32'(rdy_seen), 32'd0);
      run_div("post_rst_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      dif.E_div_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
